// File: rtl/im_loader_if.sv
// Byte-stream ingress and instruction-memory write bus for the boot-time IM loader.
// The master view belongs to the loader. The slave view belongs to the stream host and the IM array.
interface im_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [11:0] im_widx;
  logic [31:0] im_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, im_we, im_waddr, im_widx, im_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, im_we, im_waddr, im_widx, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Boot loader for instruction memory. It packs a big-endian byte stream (header N, then N words)
// into IM writes at PCBASE and holds the CPU in reset until the load completes.
// Define IM_LOADER_CKSUM_EN to require a trailing XOR checksum word after the data.
module im_loader #(
  parameter logic [31:0] PCBASE = 32'h0000_3000,
  parameter int          DEPTH  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  im_loader_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold,
  output logic [12:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef IM_LOADER_CKSUM_EN
    S_CKS,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef IM_LOADER_CKSUM_EN
  localparam state_t S_END = S_CKS;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [31:0] shreg, shreg_nxt;
  logic [12:0] n_words, n_words_nxt;
  logic [11:0] idx, idx_nxt;
  logic [12:0] word_cnt_nxt;
  logic        we, we_nxt;
  logic [31:0] wdata, wdata_nxt;
  logic [11:0] widx, widx_nxt;
  logic [31:0] waddr, waddr_nxt;
`ifdef IM_LOADER_CKSUM_EN
  logic [31:0] xacc, xacc_nxt;
`endif

  logic        accept, last_byte;
  logic [31:0] shifted;

  assign accept    = bus.in_valid && bus.in_ready;
  assign shifted   = {shreg[23:0], bus.in_data};
  assign last_byte = accept && (byte_cnt == 2'd3);

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    shreg_nxt    = shreg;
    n_words_nxt  = n_words;
    idx_nxt      = idx;
    word_cnt_nxt = word_cnt;
    we_nxt       = 1'b0;
    wdata_nxt    = wdata;
    widx_nxt     = widx;
    waddr_nxt    = waddr;
`ifdef IM_LOADER_CKSUM_EN
    xacc_nxt     = xacc;
`endif

    // Every receiving state shifts accepted bytes in, MSB first.
    if (accept) begin
      shreg_nxt    = shifted;
      byte_cnt_nxt = byte_cnt + 2'd1;
    end

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt    = S_HDR;
          byte_cnt_nxt = 2'd0;
          idx_nxt      = '0;
          word_cnt_nxt = '0;
`ifdef IM_LOADER_CKSUM_EN
          xacc_nxt     = '0;
`endif
        end
      end
      S_HDR: begin
        if (last_byte) begin
          if (shifted > 32'(DEPTH)) begin
            state_nxt = S_ERR;
          end else if (shifted == 32'd0) begin
            state_nxt = S_END;
          end else begin
            state_nxt   = S_DATA;
            n_words_nxt = shifted[12:0];
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          we_nxt       = 1'b1;
          wdata_nxt    = shifted;
          widx_nxt     = idx;
          waddr_nxt    = PCBASE + {18'd0, idx, 2'b00};
          idx_nxt      = idx + 12'd1;
          word_cnt_nxt = word_cnt + 13'd1;
`ifdef IM_LOADER_CKSUM_EN
          xacc_nxt     = xacc ^ shifted;
`endif
          if ((word_cnt + 13'd1) == n_words) state_nxt = S_END;
        end
      end
`ifdef IM_LOADER_CKSUM_EN
      S_CKS: begin
        if (last_byte) state_nxt = (shifted == xacc) ? S_DONE : S_ERR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      shreg    <= '0;
      n_words  <= '0;
      idx      <= '0;
      word_cnt <= '0;
      we       <= 1'b0;
      wdata    <= '0;
      widx     <= '0;
      waddr    <= PCBASE;
`ifdef IM_LOADER_CKSUM_EN
      xacc     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      shreg    <= shreg_nxt;
      n_words  <= n_words_nxt;
      idx      <= idx_nxt;
      word_cnt <= word_cnt_nxt;
      we       <= we_nxt;
      wdata    <= wdata_nxt;
      widx     <= widx_nxt;
      waddr    <= waddr_nxt;
`ifdef IM_LOADER_CKSUM_EN
      xacc     <= xacc_nxt;
`endif
    end
  end

`ifdef IM_LOADER_CKSUM_EN
  assign busy = (state == S_HDR) || (state == S_DATA) || (state == S_CKS);
`else
  assign busy = (state == S_HDR) || (state == S_DATA);
`endif
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign cpu_hold     = ~done;
  assign bus.in_ready = busy;
  assign bus.im_we    = we;
  assign bus.im_wdata = wdata;
  assign bus.im_widx  = widx;
  assign bus.im_waddr = waddr;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: normal load, oversize header, empty image, reset mid-load,
// start ignored during DATA, a full DEPTH image, and (with IM_LOADER_CKSUM_EN) checksum pass/fail.
module tb_im_loader;

`ifdef IM_LOADER_CKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, error, cpu_hold;
  logic [12:0] word_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  int          we_cnt = 0;
  int          we_base;

  im_loader_if bus();

  im_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.im_we === 1'b1) we_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte_rand(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"}, bus.in_ready, 0);
    check({tag, ".im_we"},    bus.im_we, 0);
    check({tag, ".waddr"},    bus.im_waddr, 32'h3000);
    check({tag, ".widx"},     bus.im_widx, 0);
    check({tag, ".wdata"},    bus.im_wdata, 0);
    check({tag, ".busy"},     busy, 0);
    check({tag, ".done"},     done, 0);
    check({tag, ".error"},    error, 0);
    check({tag, ".cpu_hold"}, cpu_hold, 1);
    check({tag, ".word_cnt"}, word_cnt, 0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Two-word load, back-to-back bytes.
    pulse_start();
    check("s1.busy", busy, 1);
    check("s1.ready", bus.in_ready, 1);
    send_word(32'h0000_0002);
    check("s1.hdr_we", bus.im_we, 0);
    send_word(32'h3408_0005);
    check("s1.w0.we", bus.im_we, 1);
    check("s1.w0.idx", bus.im_widx, 0);
    check("s1.w0.addr", bus.im_waddr, 32'h3000);
    check("s1.w0.data", bus.im_wdata, 32'h3408_0005);
    check("s1.w0.cnt", word_cnt, 1);
    check("s1.w0.done", done, 0);
    send_word(32'h0000_000C);
    check("s1.w1.we", bus.im_we, 1);
    check("s1.w1.idx", bus.im_widx, 1);
    check("s1.w1.addr", bus.im_waddr, 32'h3004);
    check("s1.w1.data", bus.im_wdata, 32'h0000_000C);
    check("s1.w1.cnt", word_cnt, 2);
    check("s1.w1.done", done, !CKS_EN);
    if (CKS_EN) send_word(32'h3408_0009);
    check("s1.done", done, 1);
    check("s1.hold", cpu_hold, 0);
    check("s1.ready_off", bus.in_ready, 0);
    tick();
    check("s1.we_off", bus.im_we, 0);

    // Oversize header goes to ERR, then a valid one-word image recovers.
    tick();
    we_base = we_cnt;
    pulse_start();
    send_word(32'h0000_1001);
    check("s2.error", error, 1);
    check("s2.ready", bus.in_ready, 0);
    check("s2.hold", cpu_hold, 1);
    check("s2.busy", busy, 0);
    send_word(32'hFFFF_FFFF);
    tick();
    check("s2.stuck", error, 1);
    check("s2.no_we", we_cnt - we_base, 0);
    pulse_start();
    check("s2.restart", busy, 1);
    check("s2.err_clr", error, 0);
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    check("s2.we", bus.im_we, 1);
    check("s2.idx", bus.im_widx, 0);
    check("s2.data", bus.im_wdata, 32'hDEAD_BEEF);
    check("s2.cnt", word_cnt, 1);
    if (CKS_EN) send_word(32'hDEAD_BEEF);
    check("s2.done", done, 1);

    // Empty image.
    tick();
    we_base = we_cnt;
    pulse_start();
    send_word(32'h0000_0000);
    check("s3.done", done, !CKS_EN);
    check("s3.busy", busy, CKS_EN);
    if (CKS_EN) send_word(32'h0000_0000);
    check("s3.done_final", done, 1);
    check("s3.cnt", word_cnt, 0);
    tick();
    check("s3.no_we", we_cnt - we_base, 0);

    // Three-word load with stalls, reset after six data bytes.
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte_rand(8'h00);
    send_byte_rand(8'h03);
    send_byte_rand(8'h11);
    send_byte_rand(8'h22);
    send_byte_rand(8'h33);
    send_byte_rand(8'h44);
    check("s4.w0.we", bus.im_we, 1);
    check("s4.w0.data", bus.im_wdata, 32'h1122_3344);
    check("s4.w0.cnt", word_cnt, 1);
    tick();
    check("s4.stall_we", bus.im_we, 0);
    check("s4.stall_cnt", word_cnt, 1);
    send_byte_rand(8'h55);
    send_byte_rand(8'h66);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("s4.rst");
    pulse_start();
    send_word(32'h0000_0002);
    send_word(32'hA5A5_A5A5);
    check("s4.f0.idx", bus.im_widx, 0);
    check("s4.f0.addr", bus.im_waddr, 32'h3000);
    check("s4.f0.cnt", word_cnt, 1);
    send_word(32'h5A5A_5A5A);
    check("s4.f1.idx", bus.im_widx, 1);
    check("s4.f1.data", bus.im_wdata, 32'h5A5A_5A5A);
    if (CKS_EN) send_word(32'hFFFF_FFFF);
    check("s4.done", done, 1);

    // start pulsed in DATA is ignored.
    tick();
    pulse_start();
    send_word(32'h0000_0003);
    send_word(32'h0102_0304);
    check("s5.cnt1", word_cnt, 1);
    send_byte(8'h05);
    send_byte(8'h06);
    pulse_start();
    check("s5.busy", busy, 1);
    check("s5.cnt_hold", word_cnt, 1);
    send_byte(8'h07);
    send_byte(8'h08);
    check("s5.w1.idx", bus.im_widx, 1);
    check("s5.w1.data", bus.im_wdata, 32'h0506_0708);
    check("s5.w1.cnt", word_cnt, 2);
    send_word(32'h090A_0B0C);
    check("s5.w2.idx", bus.im_widx, 2);
    check("s5.w2.addr", bus.im_waddr, 32'h3008);
    check("s5.w2.cnt", word_cnt, 3);
    if (CKS_EN) send_word(32'h0D0E_0F00);
    check("s5.done", done, 1);

    // Full DEPTH image: last write lands at idx 4095.
    tick();
    pulse_start();
    send_word(32'h0000_1000);
    check("s6.accepted", busy, 1);
    for (int i = 0; i < 4095; i++) send_word(32'(i));
    send_word(32'h0000_0FFF);
    check("s6.idx", bus.im_widx, 12'hFFF);
    check("s6.addr", bus.im_waddr, 32'h0000_6FFC);
    check("s6.data", bus.im_wdata, 32'h0000_0FFF);
    check("s6.cnt", word_cnt, 13'h1000);
    if (CKS_EN) send_word(32'h0000_0000);
    check("s6.done", done, 1);

`ifdef IM_LOADER_CKSUM_EN
    // Checksum match and mismatch.
    tick();
    pulse_start();
    send_word(32'h0000_0002);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    check("s7.we", bus.im_we, 1);
    check("s7.cks_wait", done, 0);
    send_word(32'h3333_3333);
    check("s7.done", done, 1);
    tick();
    we_base = we_cnt;
    pulse_start();
    send_word(32'h0000_0002);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3334);
    check("s7.error", error, 1);
    tick();
    check("s7.writes", we_cnt - we_base, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
